// File: rtl/prbs_multi_checker.sv
// rtl/prbs_multi_checker.sv - W-bit-per-cycle self-synchronising PRBS7/9/15/23/31 checker
// SEARCH/LOCKED lock tracking with saturating bit, bit-error and lock-loss counters.

module prbs_multi_checker #(
  parameter int W          = 8,
  parameter int CW         = 32,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [W-1:0]  data_in,
  input  logic          data_in_valid,
  input  logic [2:0]    poly_sel,
  input  logic          clear_counts,
  output logic          locked,
  output logic [6:0]    word_errors,
  output logic [CW-1:0] total_bits,
  output logic [CW-1:0] total_bit_errors,
  output logic [CW-1:0] lock_loss_count
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state_q;
  logic [30:0]   hist_q;
  logic [4:0]    fill_q;
  logic [7:0]    good_q;
  logic [7:0]    bad_q;
  logic [2:0]    poly_q;
  logic [6:0]    werr_q;
  logic [CW-1:0] bits_q;
  logic [CW-1:0] errs_q;
  logic [CW-1:0] loss_q;

  logic [4:0]    order;
  logic [4:0]    tap2;
  logic [4:0]    tap_hi;
  logic [4:0]    tap_lo;
  logic [30:0]   hist_d;
  logic [W-1:0]  mism_d;
  logic [6:0]    popcnt_d;
  logic          pred_bit;
  logic [7:0]    fill_sum;
  logic [4:0]    fill_next;
  logic          compared;
  logic          word_bad;
  logic [7:0]    good_inc;
  logic [7:0]    bad_inc;

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [7:0] b);
    logic [CW+7:0] sum;
    sum = {8'd0, a} + {{CW{1'b0}}, b};
    if (|sum[CW+7:CW]) return {CW{1'b1}};
    return sum[CW-1:0];
  endfunction

  always_comb begin
    order = 5'd31;
    tap2  = 5'd28;
    case (poly_sel)
      3'd0:    begin order = 5'd7;  tap2 = 5'd6;  end
      3'd1:    begin order = 5'd9;  tap2 = 5'd5;  end
      3'd2:    begin order = 5'd15; tap2 = 5'd14; end
      3'd3:    begin order = 5'd23; tap2 = 5'd18; end
      default: begin order = 5'd31; tap2 = 5'd28; end
    endcase
    tap_hi = order - 5'd1;
    tap_lo = tap2 - 5'd1;
  end

  // Bits are walked earliest-first; when locked the prediction, not the
  // received bit, feeds the history so line errors never propagate.
  always_comb begin
    hist_d   = hist_q;
    mism_d   = '0;
    pred_bit = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      pred_bit  = hist_d[tap_hi] ^ hist_d[tap_lo];
      mism_d[i] = pred_bit ^ data_in[i];
      hist_d    = {hist_d[29:0], (state_q == LOCKED) ? pred_bit : data_in[i]};
    end
  end

  always_comb begin
    popcnt_d = '0;
    for (int i = 0; i < W; i++) begin
      popcnt_d = popcnt_d + {6'd0, mism_d[i]};
    end
  end

  assign fill_sum  = 8'(fill_q) + 8'(W);
  assign fill_next = (fill_sum > 8'd31) ? 5'd31 : fill_sum[4:0];
  assign compared  = (fill_q >= order);
  assign word_bad  = |mism_d;
  assign good_inc  = good_q + 8'd1;
  assign bad_inc   = bad_q + 8'd1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= SEARCH;
      hist_q  <= '0;
      fill_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      poly_q  <= poly_sel;
      werr_q  <= '0;
      bits_q  <= '0;
      errs_q  <= '0;
      loss_q  <= '0;
    end else begin
      poly_q <= poly_sel;
      if (poly_sel != poly_q) begin
        state_q <= SEARCH;
        fill_q  <= '0;
        good_q  <= '0;
      end else if (data_in_valid) begin
        hist_q <= hist_d;
        case (state_q)
          SEARCH: begin
            fill_q <= fill_next;
            werr_q <= compared ? popcnt_d : 7'd0;
            if (!compared || word_bad) begin
              good_q <= '0;
            end else if (good_inc == 8'(LOCK_CNT)) begin
              state_q <= LOCKED;
              good_q  <= '0;
              bad_q   <= '0;
            end else begin
              good_q <= good_inc;
            end
          end
          LOCKED: begin
            werr_q <= popcnt_d;
            bits_q <= sat_add(bits_q, 8'(W));
            errs_q <= sat_add(errs_q, {1'b0, popcnt_d});
            if (!word_bad) begin
              bad_q <= '0;
            end else if (bad_inc == 8'(UNLOCK_CNT)) begin
              state_q <= SEARCH;
              fill_q  <= '0;
              good_q  <= '0;
              bad_q   <= '0;
              loss_q  <= sat_add(loss_q, 8'd1);
            end else begin
              bad_q <= bad_inc;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
      if (clear_counts) begin
        bits_q <= '0;
        errs_q <= '0;
        loss_q <= '0;
      end
    end
  end

  assign locked           = (state_q == LOCKED);
  assign word_errors      = werr_q;
  assign total_bits       = bits_q;
  assign total_bit_errors = errs_q;
  assign lock_loss_count  = loss_q;

endmodule
